// File: rtl/can_tx_frame_ctrl_if.sv
// can_tx_frame_ctrl_if: request/status bundle between the TX register block
// (master) and the CAN transmit frame sequencer (slave).
interface can_tx_frame_ctrl_if;
  logic        tx_req;
  logic [10:0] tx_id;
  logic        tx_rtr;
  logic [3:0]  tx_dlc;
  logic [63:0] tx_data;
  logic        tx_busy;
  logic        tx_done;
  logic        ack_error;
  logic        arb_lost;

  modport master (
    output tx_req, tx_id, tx_rtr, tx_dlc, tx_data,
    input  tx_busy, tx_done, ack_error, arb_lost
  );

  modport slave (
    input  tx_req, tx_id, tx_rtr, tx_dlc, tx_data,
    output tx_busy, tx_done, ack_error, arb_lost
  );
endinterface

// File: rtl/can_tx_frame_ctrl.sv
// can_tx_frame_ctrl: serialises one standard CAN data/remote frame into the
// bit stuffer, computes CRC-15, checks the ACK slot and reports completion.
// Optional feature macro CAN_TX_ARB_LOST_EN: abort with an arb_lost pulse
// when a recessive ID/RTR bit is read back dominant.
module can_tx_frame_ctrl #(
  parameter int IFS_BITS = 3,
  parameter int EOF_BITS = 7
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      reset_mode,
  input  logic                      sample_point,
  input  logic                      bit_start_point,
  input  logic                      insert_stuff_bit,
  input  logic                      stuffed_tx_bit,
  input  logic                      rx_bit,
  can_tx_frame_ctrl_if.slave        bus,
  output logic                      tx_frame_tx_bit,
  output logic                      bit_stuffing_en,
  output logic                      stuff_clr
);

  typedef enum logic [3:0] {
    S_IDLE, S_SOF, S_ID, S_RTR, S_IDE, S_R0, S_DLC, S_DATA,
    S_CRC, S_CRC_DEL, S_ACK_SLOT, S_ACK_DEL, S_EOF, S_IFS
  } state_t;

  state_t      state;
  state_t      bus_state;
  state_t      nxt_state;
  logic [5:0]  bit_idx;
  logic [5:0]  nxt_idx;
  logic [14:0] crc;
  logic [14:0] nxt_crc;
  logic [10:0] id_q;
  logic        rtr_q;
  logic [3:0]  dlc_q;
  logic [63:0] data_q;
  logic        busy_q;
  logic        done_q;
  logic        ack_flag;
  logic        ack_err_q;
  logic        consume;
  logic [6:0]  data_bits;

  // A presented bit is taken by the stuffer unless this bit start carries a stuff bit.
  assign consume   = bit_start_point && (state != S_IDLE) &&
                     !(bit_stuffing_en && insert_stuff_bit);
  assign data_bits = rtr_q ? 7'd0 : (dlc_q > 4'd8) ? 7'd64 : {dlc_q, 3'b000};

  // Raw bit value for a given field position, using the latched request.
  function automatic logic present_bit(input state_t s, input logic [5:0] idx,
                                       input logic [14:0] c);
    logic b;
    case (s)
      S_SOF:  b = 1'b0;
      S_ID:   b = id_q[4'd10 - idx[3:0]];
      S_RTR:  b = rtr_q;
      S_IDE:  b = 1'b0;
      S_R0:   b = 1'b0;
      S_DLC:  b = dlc_q[2'd3 - idx[1:0]];
      S_DATA: b = data_q[6'd63 - idx];
      S_CRC:  b = c[4'd14 - idx[3:0]];
      default: b = 1'b1;
    endcase
    return b;
  endfunction

  // Field sequencing: where the pointer goes after the current bit is consumed.
  always_comb begin
    nxt_state = state;
    nxt_idx   = bit_idx + 6'd1;
    case (state)
      S_SOF:      begin nxt_state = S_ID;  nxt_idx = 6'd0; end
      S_ID:       if (bit_idx == 6'd10) begin nxt_state = S_RTR; nxt_idx = 6'd0; end
      S_RTR:      begin nxt_state = S_IDE; nxt_idx = 6'd0; end
      S_IDE:      begin nxt_state = S_R0;  nxt_idx = 6'd0; end
      S_R0:       begin nxt_state = S_DLC; nxt_idx = 6'd0; end
      S_DLC:      if (bit_idx == 6'd3) begin
                    nxt_state = (data_bits == 7'd0) ? S_CRC : S_DATA;
                    nxt_idx   = 6'd0;
                  end
      S_DATA:     if ({1'b0, bit_idx} == data_bits - 7'd1) begin
                    nxt_state = S_CRC;
                    nxt_idx   = 6'd0;
                  end
      S_CRC:      if (bit_idx == 6'd14) begin nxt_state = S_CRC_DEL; nxt_idx = 6'd0; end
      S_CRC_DEL:  begin nxt_state = S_ACK_SLOT; nxt_idx = 6'd0; end
      S_ACK_SLOT: begin nxt_state = S_ACK_DEL;  nxt_idx = 6'd0; end
      S_ACK_DEL:  begin nxt_state = S_EOF;      nxt_idx = 6'd0; end
      S_EOF:      if (bit_idx == 6'(EOF_BITS - 1)) begin nxt_state = S_IFS; nxt_idx = 6'd0; end
      S_IFS:      if (bit_idx == 6'(IFS_BITS - 1)) begin nxt_state = S_IDLE; nxt_idx = 6'd0; end
      default:    begin nxt_state = S_IDLE; nxt_idx = 6'd0; end
    endcase
  end

  // CRC-15 advance for the consumed bit; frozen once the DATA field is done.
  always_comb begin
    nxt_crc = crc;
    if (state inside {S_SOF, S_ID, S_RTR, S_IDE, S_R0, S_DLC, S_DATA}) begin
      nxt_crc = {crc[13:0], 1'b0} ^ ((tx_frame_tx_bit ^ crc[14]) ? 15'h4599 : 15'h0000);
    end
  end

  // Frame sequencer with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      bus_state       <= S_IDLE;
      bit_idx         <= 6'd0;
      crc             <= 15'd0;
      id_q            <= 11'd0;
      rtr_q           <= 1'b0;
      dlc_q           <= 4'd0;
      data_q          <= 64'd0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      ack_flag        <= 1'b0;
      ack_err_q       <= 1'b0;
      tx_frame_tx_bit <= 1'b1;
      bit_stuffing_en <= 1'b0;
      stuff_clr       <= 1'b0;
    end else if (reset_mode) begin
      state           <= S_IDLE;
      bus_state       <= S_IDLE;
      bit_idx         <= 6'd0;
      crc             <= 15'd0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      ack_flag        <= 1'b0;
      ack_err_q       <= 1'b0;
      tx_frame_tx_bit <= 1'b1;
      bit_stuffing_en <= 1'b0;
      stuff_clr       <= 1'b1;
    end else begin
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      stuff_clr <= 1'b0;
      if (sample_point && (bus_state == S_ACK_SLOT) && rx_bit) begin
        ack_flag <= 1'b1;
      end
`ifdef CAN_TX_ARB_LOST_EN
      if (sample_point && ((bus_state == S_ID) || (bus_state == S_RTR)) &&
          stuffed_tx_bit && !rx_bit) begin
        state           <= S_IDLE;
        bus_state       <= S_IDLE;
        bit_idx         <= 6'd0;
        busy_q          <= 1'b0;
        ack_flag        <= 1'b0;
        tx_frame_tx_bit <= 1'b1;
        bit_stuffing_en <= 1'b0;
        stuff_clr       <= 1'b1;
      end else
`endif
      if (state == S_IDLE) begin
        if (bus.tx_req) begin
          id_q            <= bus.tx_id;
          rtr_q           <= bus.tx_rtr;
          dlc_q           <= bus.tx_dlc;
          data_q          <= bus.tx_data;
          state           <= S_SOF;
          bit_idx         <= 6'd0;
          crc             <= 15'd0;
          busy_q          <= 1'b1;
          ack_flag        <= 1'b0;
          bit_stuffing_en <= 1'b1;
          tx_frame_tx_bit <= 1'b0;
        end
      end else if (consume) begin
        state           <= nxt_state;
        bit_idx         <= nxt_idx;
        crc             <= nxt_crc;
        bus_state       <= state;
        tx_frame_tx_bit <= present_bit(nxt_state, nxt_idx, nxt_crc);
        if (state == S_CRC_DEL) begin
          bit_stuffing_en <= 1'b0;
        end
        if ((state == S_IFS) && (nxt_state == S_IDLE)) begin
          done_q    <= 1'b1;
          stuff_clr <= 1'b1;
          busy_q    <= 1'b0;
          ack_err_q <= ack_flag;
          ack_flag  <= 1'b0;
        end
      end
    end
  end

`ifdef CAN_TX_ARB_LOST_EN
  logic arb_q;

  // One-cycle arbitration-lost pulse, raised on the same sample point that aborts the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb_q <= 1'b0;
    end else begin
      arb_q <= !reset_mode && sample_point &&
               ((bus_state == S_ID) || (bus_state == S_RTR)) &&
               stuffed_tx_bit && !rx_bit;
    end
  end

  assign bus.arb_lost = arb_q;
`else
  logic unused_stuffed;

  assign unused_stuffed = stuffed_tx_bit;
  assign bus.arb_lost   = 1'b0;
`endif

  assign bus.tx_busy   = busy_q;
  assign bus.tx_done   = done_q;
  assign bus.ack_error = ack_err_q;

endmodule

// File: tb/tb_can_tx_frame_ctrl.sv
// tb_can_tx_frame_ctrl: drives can_tx_frame_ctrl with a bit-timing generator,
// a behavioural bit stuffer and a loop-back bus, and compares the bus bit stream
// against a golden frame built from the CAN frame format rules.
`timescale 1ns/1ps
module tb_can_tx_frame_ctrl;
  localparam int IFS_BITS  = 3;
  localparam int EOF_BITS  = 7;
  localparam int BT        = 8;
  localparam int SAMPLE_PH = 5;

  logic clk              = 1'b0;
  logic rst_n            = 1'b0;
  logic reset_mode       = 1'b0;
  logic sample_point     = 1'b0;
  logic bit_start_point  = 1'b0;
  logic insert_stuff_bit = 1'b0;
  logic stuffed_tx_bit   = 1'b1;
  logic rx_bit           = 1'b1;
  logic tx_frame_tx_bit;
  logic bit_stuffing_en;
  logic stuff_clr;

  can_tx_frame_ctrl_if bus_if();

  can_tx_frame_ctrl #(.IFS_BITS(IFS_BITS), .EOF_BITS(EOF_BITS)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .reset_mode       (reset_mode),
    .sample_point     (sample_point),
    .bit_start_point  (bit_start_point),
    .insert_stuff_bit (insert_stuff_bit),
    .stuffed_tx_bit   (stuffed_tx_bit),
    .rx_bit           (rx_bit),
    .bus              (bus_if),
    .tx_frame_tx_bit  (tx_frame_tx_bit),
    .bit_stuffing_en  (bit_stuffing_en),
    .stuff_clr        (stuff_clr)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Bench-side stuffer / bus state
  int   phase     = 0;
  logic ld_bit    = 1'b1;
  logic ld_en     = 1'b0;
  logic ld_ins    = 1'b0;
  int   run_cnt   = 0;
  logic last_bit  = 1'b1;
  int   bus_k     = 0;
  bit   recording = 1'b0;
  bit   ack_dom   = 1'b1;
  int   ack_pos   = -1;
  int   arb_k     = -1;
  int   done_cnt  = 0;
  int   arb_cnt   = 0;
  int   arb_total = 0;
  logic ack_at_done = 1'b0;
  bit   obs[$];
  bit   ds[$];

  // Reference model
  bit          raw[$];
  bit          gold[$];
  int          stf_len;
  int          n_stuff;
  logic [14:0] crc_ref;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Builds the unstuffed and stuffed bit streams of a frame from its fields.
  function automatic void build_golden(input logic [10:0] id, input logic rtr,
                                       input logic [3:0] dlc, input logic [63:0] data);
    int nbytes;
    int run;
    bit run_last;
    bit fb;
    raw.delete();
    gold.delete();
    raw.push_back(1'b0);
    for (int i = 10; i >= 0; i--) raw.push_back(id[i]);
    raw.push_back(rtr);
    raw.push_back(1'b0);
    raw.push_back(1'b0);
    for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
    nbytes = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
    for (int i = 0; i < nbytes * 8; i++) raw.push_back(data[63 - i]);
    crc_ref = 15'd0;
    foreach (raw[j]) begin
      fb      = raw[j] ^ crc_ref[14];
      crc_ref = {crc_ref[13:0], 1'b0};
      if (fb) crc_ref = crc_ref ^ 15'h4599;
    end
    for (int i = 14; i >= 0; i--) raw.push_back(crc_ref[i]);
    stf_len = raw.size();
    repeat (3 + EOF_BITS + IFS_BITS) raw.push_back(1'b1);
    n_stuff  = 0;
    run      = 0;
    run_last = 1'b1;
    for (int j = 0; j < raw.size(); j++) begin
      gold.push_back(raw[j]);
      if (run != 0 && raw[j] == run_last) run++;
      else run = 1;
      run_last = raw[j];
      if (j < stf_len && run == 5) begin
        gold.push_back(~raw[j]);
        run_last = ~raw[j];
        run      = 1;
        n_stuff++;
      end
    end
  endfunction

  // Removes stuff bits from the observed bus stream.
  function automatic void destuff_obs();
    bit skip;
    bit last;
    int run;
    skip = 1'b0;
    last = 1'b1;
    run  = 0;
    ds.delete();
    foreach (obs[j]) begin
      if (skip) begin
        skip = 1'b0;
        last = obs[j];
        run  = 1;
      end else begin
        ds.push_back(obs[j]);
        if (ds.size() <= stf_len) begin
          if (run != 0 && obs[j] == last) run++;
          else run = 1;
          last = obs[j];
          if (run == 5) skip = 1'b1;
        end
      end
    end
  endfunction

  // One clock: stuffer load, bus loop-back, event monitors, timing pulses.
  task automatic tick();
    logic b;
    @(negedge clk);
    if (bit_start_point) begin
      b = (ld_en && ld_ins) ? ~last_bit : ld_bit;
      if (run_cnt != 0 && b == last_bit) run_cnt++;
      else run_cnt = 1;
      last_bit = b;
      if (!ld_en) run_cnt = 0;
      stuffed_tx_bit = b;
      if (recording) obs.push_back(b);
      rx_bit = b;
      if (ack_dom && bus_k == ack_pos) rx_bit = 1'b0;
      if (bus_k == arb_k) rx_bit = 1'b0;
      bus_k++;
    end
    if (stuff_clr || reset_mode) run_cnt = 0;
    if (bus_if.tx_done) begin
      done_cnt++;
      ack_at_done = bus_if.ack_error;
      recording   = 1'b0;
    end
    if (bus_if.arb_lost) begin
      arb_cnt++;
      arb_total++;
      recording = 1'b0;
    end
    phase            = (phase + 1) % BT;
    bit_start_point  = (phase == 0);
    sample_point     = (phase == SAMPLE_PH);
    insert_stuff_bit = 1'b0;
    if (bit_start_point) begin
      ld_bit           = tx_frame_tx_bit;
      ld_en            = bit_stuffing_en;
      ld_ins           = ld_en && (run_cnt == 5);
      insert_stuff_bit = ld_ins;
    end
  endtask

  // Requests one frame, follows it on the bus and checks the outcome.
  task automatic applyStimulus(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                               input logic [63:0] data, input bit ack_d,
                               input int abort_at, input int arb_at, input bit poke);
    int   budget;
    int   mism;
    logic [14:0] crc_obs;
    build_golden(id, rtr, dlc, data);
    ack_dom  = ack_d;
    ack_pos  = gold.size() - IFS_BITS - EOF_BITS - 2;
    arb_k    = -1;
    obs.delete();
    done_cnt = 0;
    arb_cnt  = 0;
    bus_if.tx_id   = id;
    bus_if.tx_rtr  = rtr;
    bus_if.tx_dlc  = dlc;
    bus_if.tx_data = data;
    bus_if.tx_req  = 1'b1;
    tick();
    bus_if.tx_req = 1'b0;
    checkOutput("busy_after_req", bus_if.tx_busy, 1);
    checkOutput("sof_presented", tx_frame_tx_bit, 0);
    recording = 1'b1;
    bus_k     = 0;
    arb_k     = arb_at;
    budget    = 0;
    while (done_cnt == 0 && arb_cnt == 0 && budget < 4000) begin
      if (poke) begin
        bus_if.tx_req  = (bus_k == 10);
        bus_if.tx_id   = ~id;
        bus_if.tx_data = ~data;
      end
      if (abort_at >= 0 && bus_k == abort_at) break;
      tick();
      budget++;
    end
    bus_if.tx_req = 1'b0;
    arb_k = -1;
    if (abort_at >= 0) begin
      reset_mode = 1'b1;
      tick();
      reset_mode = 1'b0;
      recording  = 1'b0;
      checkOutput("abort_reached", bus_k, abort_at);
      checkOutput("abort_tx_bit", tx_frame_tx_bit, 1);
      checkOutput("abort_busy", bus_if.tx_busy, 0);
      checkOutput("abort_stuff_en", bit_stuffing_en, 0);
      checkOutput("abort_stuff_clr", stuff_clr, 1);
      repeat (30 * BT) tick();
      checkOutput("abort_no_done", done_cnt, 0);
    end else if (arb_at >= 0) begin
      checkOutput("arb_lost_seen", arb_cnt, 1);
      checkOutput("arb_busy", bus_if.tx_busy, 0);
      checkOutput("arb_tx_bit", tx_frame_tx_bit, 1);
      tick();
      checkOutput("arb_pulse_width", bus_if.arb_lost, 0);
      repeat (30 * BT) tick();
      checkOutput("arb_no_done", done_cnt, 0);
    end else begin
      checkOutput("done_seen", done_cnt, 1);
      checkOutput("ack_error_at_done", ack_at_done, !ack_d);
      checkOutput("busy_at_done", bus_if.tx_busy, 0);
      checkOutput("frame_length", obs.size(), gold.size());
      mism = 0;
      for (int j = 0; j < obs.size() && j < gold.size(); j++) begin
        if (obs[j] != gold[j]) mism++;
      end
      checkOutput("frame_bit_errors", mism, 0);
      destuff_obs();
      crc_obs = 15'd0;
      for (int i = 0; i < 15; i++) crc_obs = {crc_obs[13:0], ds[stf_len - 15 + i]};
      checkOutput("crc_field", crc_obs, crc_ref);
      tick();
      checkOutput("done_pulse_width", bus_if.tx_done, 0);
    end
  endtask

  initial begin
    logic [63:0] rdata;
    bus_if.tx_req  = 1'b0;
    bus_if.tx_id   = 11'd0;
    bus_if.tx_rtr  = 1'b0;
    bus_if.tx_dlc  = 4'd0;
    bus_if.tx_data = 64'd0;
    repeat (4) tick();
    checkOutput("reset_tx_bit", tx_frame_tx_bit, 1);
    checkOutput("reset_busy", bus_if.tx_busy, 0);
    checkOutput("reset_done", bus_if.tx_done, 0);
    checkOutput("reset_stuff_en", bit_stuffing_en, 0);
    checkOutput("reset_stuff_clr", stuff_clr, 0);
    rst_n = 1'b1;
    repeat (2 * BT) tick();

    // Data frame, one byte, ACK given
    applyStimulus(11'h123, 1'b0, 4'd1, 64'hA500_0000_0000_0000, 1'b1, -1, -1, 1'b0);

    // All-dominant header: stuff bit right after SOF + four ID zeros
    applyStimulus(11'h000, 1'b0, 4'd0, 64'd0, 1'b1, -1, -1, 1'b0);
    checkOutput("zero_stuff_pos5", obs[5], 1);
    checkOutput("zero_held_bit6", obs[6], 0);
    checkOutput("zero_total_bits", obs.size(), 44 + IFS_BITS + n_stuff);

    // Remote frame with dlc 8: no DATA field
    applyStimulus(11'h5A3, 1'b1, 4'd8, 64'hFFFF_0000_1234_5678, 1'b1, -1, -1, 1'b0);
    checkOutput("rtr_bit", ds[12], 1);
    checkOutput("rtr_dlc_field", {ds[15], ds[16], ds[17], ds[18]}, 4'b1000);

    // No acknowledgement from the bus
    applyStimulus(11'h2F0, 1'b0, 4'd2, 64'hDEAD_0000_0000_0000, 1'b0, -1, -1, 1'b0);

    // Soft reset inside the DATA field, then a fresh frame
    applyStimulus(11'h2AB, 1'b0, 4'd4, 64'h0F0F_3C3C_0000_0000, 1'b1, 25, -1, 1'b0);
    applyStimulus(11'h456, 1'b0, 4'd3, 64'h0102_0300_0000_0000, 1'b1, -1, -1, 1'b0);

`ifdef CAN_TX_ARB_LOST_EN
    // Lose arbitration on the first recessive ID bit
    applyStimulus(11'h400, 1'b0, 4'd2, 64'h1122_0000_0000_0000, 1'b1, -1, 1, 1'b0);
`endif

    // Randomised frames, some with a request poked while busy
    for (int n = 0; n < 6; n++) begin
      rdata = {$urandom, $urandom};
      applyStimulus(11'($urandom_range(0, 2047)), 1'($urandom_range(0, 3) == 0),
                    4'($urandom_range(0, 15)), rdata, 1'($urandom_range(0, 1)),
                    -1, -1, 1'($urandom_range(0, 1)));
    end

`ifndef CAN_TX_ARB_LOST_EN
    checkOutput("arb_lost_never", arb_total, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
